psum_buffer: RTL

- Partial-sum manager on the far side of the MAC array's accumulate interface.
- Responds to the array's partial_output_prepare strobe by supplying the stored 28-bit partial sums. Captures the 33-bit results on result_vld and writes them back.
- After the last input-channel pass, emits requantised 16-bit outputs instead of writing back.
- Sits between the MAC array and the layer output writer.

---
 rtl/psum_buffer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/psum_buffer.sv
// Partial-sum buffer between the MAC array and the output writer.
// Feeds stored sums back to the array and requantises the last pass.
module psum_buffer #(
  parameter int MAC_NUM = 120,
  parameter int PSUM_W  = 28,
  parameter int RES_W   = 33,
  parameter int OUT_W   = 16,
  parameter int DEPTH   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(DEPTH):0]      cfg_depth,
  input  logic [7:0]                  cfg_num_ch,
  input  logic [4:0]                  cfg_shift,
  input  logic                        cfg_relu,
  input  logic                        partial_output_prepare,
  input  logic                        result_vld,
  input  logic [MAC_NUM*RES_W-1:0]    result,
  output logic [MAC_NUM*PSUM_W-1:0]   partial_output,
  output logic                        out_vld,
  output logic [$clog2(DEPTH)-1:0]    out_pos,
  output logic [MAC_NUM*OUT_W-1:0]    out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [RES_W-1:0] P_MAX =
    RES_W'((64'sd1 <<< (PSUM_W-1)) - 64'sd1);
  localparam logic signed [RES_W-1:0] P_MIN = ~P_MAX;
  localparam logic signed [RES_W-1:0] O_MAX =
    RES_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [RES_W-1:0] O_MIN = ~O_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [AW:0]  depth_r;
  logic [7:0]   nch_r;
  logic [4:0]   shift_r;
  logic         relu_r;
  logic [AW-1:0] rd_pos, wr_pos;
  logic [7:0]   rd_ch, wr_ch;
  logic         done_d;

  logic [MAC_NUM*PSUM_W-1:0] mem [DEPTH];
  logic [MAC_NUM*PSUM_W-1:0] wdata;
  logic [MAC_NUM*PSUM_W-1:0] po_d;
  logic [MAC_NUM*OUT_W-1:0]  odata;

  function automatic logic [PSUM_W-1:0] sat_p(
    input logic signed [RES_W-1:0] r
  );
    logic signed [RES_W-1:0] v;
    v = r;
    if (r > P_MAX)      v = P_MAX;
    else if (r < P_MIN) v = P_MIN;
    return v[PSUM_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] requant(
    input logic signed [RES_W-1:0] r,
    input logic [4:0]              sh,
    input logic                    relu
  );
    logic signed [RES_W-1:0] v;
    v = r >>> sh;
    if (relu && v < 0)  v = '0;
    else if (v > O_MAX) v = O_MAX;
    else if (v < O_MIN) v = O_MIN;
    return v[OUT_W-1:0];
  endfunction

  wire run      = (state == RUN);
  wire rd_fire  = run && partial_output_prepare;
  wire wr_fire  = run && result_vld;
  wire rd_ok    = (rd_ch < nch_r);
  wire rd_wrap  = ({1'b0, rd_pos} == depth_r - 1'b1);
  wire wr_wrap  = ({1'b0, wr_pos} == depth_r - 1'b1);
  wire wr_final = (wr_ch == nch_r - 8'd1);
  wire wr_last  = wr_final && wr_wrap;
  wire wr_en    = wr_fire && !wr_final;
  wire fwd      = wr_en && (wr_pos == rd_pos);
  wire err_set  = (!run && (partial_output_prepare || result_vld))
                || (rd_fire && !rd_ok);

  always_comb begin
    wdata = '0;
    odata = '0;
    for (int i = 0; i < MAC_NUM; i++) begin
      wdata[i*PSUM_W +: PSUM_W] = sat_p(result[i*RES_W +: RES_W]);
      odata[i*OUT_W +: OUT_W] =
        requant(result[i*RES_W +: RES_W], shift_r, relu_r);
    end
  end

  // Same-cycle write to the address being read is forwarded.
  always_comb begin
    po_d = '0;
    if (rd_ok && rd_ch != 8'd0)
      po_d = fwd ? wdata : mem[rd_pos];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next_state;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (wr_fire && wr_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    done_d = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_r <= '0;
      nch_r   <= '0;
      shift_r <= '0;
      relu_r  <= 1'b0;
      rd_pos  <= '0;
      wr_pos  <= '0;
      rd_ch   <= '0;
      wr_ch   <= '0;
    end else if (state == IDLE && start) begin
      depth_r <= cfg_depth;
      nch_r   <= cfg_num_ch;
      shift_r <= cfg_shift;
      relu_r  <= cfg_relu;
      rd_pos  <= '0;
      wr_pos  <= '0;
      rd_ch   <= '0;
      wr_ch   <= '0;
    end else if (run) begin
      if (rd_fire && rd_ok) begin
        if (rd_wrap) begin
          rd_pos <= '0;
          rd_ch  <= rd_ch + 8'd1;
        end else begin
          rd_pos <= rd_pos + 1'b1;
        end
      end
      if (wr_fire) begin
        if (wr_wrap) begin
          wr_pos <= '0;
          wr_ch  <= wr_ch + 8'd1;
        end else begin
          wr_pos <= wr_pos + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_pos] <= wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      partial_output <= '0;
      out_vld        <= 1'b0;
      out_pos        <= '0;
      out_data       <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      done    <= done_d;
      if (rd_fire) partial_output <= po_d;
      if (wr_fire && wr_final) begin
        out_vld  <= 1'b1;
        out_pos  <= wr_pos;
        out_data <= odata;
      end
      if (state == IDLE && start) err <= 1'b0;
      else if (err_set)           err <= 1'b1;
    end
  end

endmodule
